rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 109 ++++++++++
 tb/tb_rr_decoder_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter with bounded tenure and a one-cycle gap between grants.
// The one-hot grant is produced by decoding the registered index.

module decoder_nbit #(
   parameter int N = 2
) (
   input  logic [N-1:0]    a,
   input  logic            enable,
   output logic [2**N-1:0] y
);
   always_comb begin
      y = '0;
      if (enable) y[a] = 1'b1;
   end
endmodule

module rr_decoder_arbiter #(
   parameter int N        = 2,
   parameter int HOLD_MAX = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [2**N-1:0] req,
   output logic [2**N-1:0] grant,
   output logic [N-1:0]    grant_idx,
   output logic            grant_valid
);
   localparam int M = 2**N;
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

   state_t       r_state, w_state_nxt;
   logic [N-1:0] r_ptr, w_ptr_nxt;
   logic [N-1:0] r_idx, w_idx_nxt;
   logic [7:0]   r_cnt, w_cnt_nxt;
   logic         r_valid, w_valid_nxt;
   logic [N-1:0] w_win_idx;
   logic         w_win_found;

   // Cyclic search from r_ptr; walking offsets downward lets the nearest hit win.
   always_comb begin
      w_win_idx   = r_ptr;
      w_win_found = 1'b0;
      for (int k = M - 1; k >= 0; k--) begin
         logic [N-1:0] cand;
         cand = r_ptr + k[N-1:0];
         if (req[cand]) begin
            w_win_idx   = cand;
            w_win_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_valid_nxt = r_valid;
      case (r_state)
         S_GRANT: begin
            if (!req[r_idx] || r_cnt == HOLD_LAST) begin
               w_state_nxt = S_GAP;
               w_valid_nxt = 1'b0;
               w_ptr_nxt   = r_idx + 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            if (w_win_found) begin
               w_state_nxt = S_GRANT;
               w_idx_nxt   = w_win_idx;
               w_valid_nxt = 1'b1;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_cnt   <= 8'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign grant_idx   = r_idx;
   assign grant_valid = r_valid;

   decoder_nbit #(.N(N)) u_dec (
      .a      (r_idx),
      .enable (r_valid),
      .y      (grant)
   );
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench: directed vector table for the listed scenarios, then random requests
// against a tenure-level model for HOLD_MAX = 4 and HOLD_MAX = 1.

module tb_rr_decoder_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'b1111;
   logic [3:0] g0, g1;
   logic [1:0] i0, i1;
   logic       v0, v1;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   rr_decoder_arbiter #(.N(2), .HOLD_MAX(4)) dut (
      .clk(clk), .reset(reset), .req(req),
      .grant(g0), .grant_idx(i0), .grant_valid(v0));

   rr_decoder_arbiter #(.N(2), .HOLD_MAX(1)) dut1 (
      .clk(clk), .reset(reset), .req(req),
      .grant(g1), .grant_idx(i1), .grant_valid(v1));

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] g;
      logic       v;
      logic [1:0] idx;
   } vec_t;

   // Model tracks who owns the resource and how many cycles it has held it.
   typedef struct {
      int owner;
      bit active;
      int used;
      int ptr;
   } mdl_t;

   vec_t tbl[$];
   mdl_t m0, m1;

   function automatic mdl_t mreset();
      mdl_t s;
      s.owner = 0; s.active = 0; s.used = 0; s.ptr = 0;
      return s;
   endfunction

   function automatic mdl_t mstep(mdl_t s, logic [3:0] r, int hmax);
      mdl_t n = s;
      if (s.active) begin
         if (r[s.owner] == 1'b0 || s.used == hmax) begin
            n.active = 0;
            n.ptr = (s.owner + 1) % 4;
         end else begin
            n.used = s.used + 1;
         end
      end else begin
         for (int k = 3; k >= 0; k--)
            if (r[(s.ptr + k) % 4]) begin
               n.owner = (s.ptr + k) % 4;
               n.active = 1;
               n.used = 1;
            end
      end
      return n;
   endfunction

   function automatic logic [6:0] mexp(mdl_t s);
      logic [3:0] g;
      g = s.active ? 4'(1 << s.owner) : 4'b0000;
      return {g, s.active, 2'(s.owner)};
   endfunction

   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got grant=%b valid=%b idx=%0d, want grant=%b valid=%b idx=%0d",
                  nm, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic add(input logic rst, input logic [3:0] r, input logic [3:0] g,
                      input logic v, input logic [1:0] idx);
      vec_t e;
      e.rst = rst; e.req = r; e.g = g; e.v = v; e.idx = idx;
      tbl.push_back(e);
   endtask

   initial begin
      // reset held high while all request
      add(1, 4'b1111, 4'b0000, 0, 0);
      // full rotation under continuous request
      for (int t = 0; t < 4; t++) begin
         for (int c = 0; c < 4; c++) add(0, 4'b1111, 4'(1 << t), 1, 2'(t));
         add(0, 4'b1111, 4'b0000, 0, 2'(t));
      end
      add(0, 4'b1111, 4'b0001, 1, 0);
      // early release of index 2, then pointer at 3
      add(1, 4'b0000, 4'b0000, 0, 0);
      for (int c = 0; c < 3; c++) add(0, 4'b0100, 4'b0100, 1, 2);
      add(0, 4'b1001, 4'b0000, 0, 2);
      add(0, 4'b1001, 4'b1000, 1, 3);
      // wrap-around search
      add(1, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b1000, 4'b1000, 1, 3);
      add(0, 4'b0001, 4'b0000, 0, 3);
      add(0, 4'b0001, 4'b0001, 1, 0);
      add(0, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0001, 4'b0001, 1, 0);
      // mid-tenure reset; pointer must restart at 0
      add(1, 4'b0000, 4'b0000, 0, 0);
      add(0, 4'b0010, 4'b0010, 1, 1);
      add(0, 4'b0000, 4'b0000, 0, 1);
      add(0, 4'b0010, 4'b0010, 1, 1);
      add(1, 4'b0010, 4'b0000, 0, 0);
      add(0, 4'b0110, 4'b0010, 1, 1);
      // idle with no requests
      add(1, 4'b0000, 4'b0000, 0, 0);
      for (int c = 0; c < 10; c++) add(0, 4'b0000, 4'b0000, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < tbl.size(); i++) begin
         reset = tbl[i].rst;
         req   = tbl[i].req;
         if (!tbl[i].rst) @(posedge clk);
         #1;
         chk($sformatf("vec%0d", i), {g0, v0, i0}, {tbl[i].g, tbl[i].v, tbl[i].idx});
         reset = 1'b0;
      end

      // random phase
      reset = 1'b1;
      #1;
      m0 = mreset();
      m1 = mreset();
      reset = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 59) == 0) begin
            reset = 1'b1;
            #1;
            m0 = mreset();
            m1 = mreset();
            chk("rnd_rst_h4", {g0, v0, i0}, mexp(m0));
            chk("rnd_rst_h1", {g1, v1, i1}, mexp(m1));
            reset = 1'b0;
         end
         @(posedge clk);
         m0 = mstep(m0, req, 4);
         m1 = mstep(m1, req, 1);
         #1;
         chk($sformatf("rnd_h4_c%0d", c), {g0, v0, i0}, mexp(m0));
         chk($sformatf("rnd_h1_c%0d", c), {g1, v1, i1}, mexp(m1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
